// File: rtl/ysyx_22050612_pkg.sv
// ysyx_22050612_pkg
//   Shared types and constants for the IFU/LSU memory arbiter:
//   FSM state encoding, request-owner encoding, the latched request
//   payload layout and the default LSU streak limit.
package ysyx_22050612_pkg;

  // Consecutive LSU grants allowed while the IFU is waiting.
  localparam int DEFAULT_MAX_LS_STREAK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Payload that is presented downstream for the in-flight transaction.
  typedef struct packed {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_22050612_arb_pick.sv
// ysyx_22050612_arb_pick
//   Owner selection between IFU and LSU plus the LSU streak counter that
//   keeps a busy LSU from starving instruction fetch.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   if_req, ls_req    raw requests from the two masters
//   idle              arbiter FSM is in IDLE this cycle
//   if_grant          IFU request accepted downstream this cycle
//   ls_grant          LSU request accepted downstream this cycle
//   pick              owner to serve when both/either request in IDLE
module ysyx_22050612_arb_pick
  import ysyx_22050612_pkg::*;
#(
  parameter int MAX_LS_STREAK = DEFAULT_MAX_LS_STREAK
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   ls_req,
  input  logic   idle,
  input  logic   if_grant,
  input  logic   ls_grant,
  output owner_e pick
);

  localparam int SW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  logic [SW-1:0] streak_reg;
  logic [SW-1:0] streak_next;

  // LSU wins contention until it has used up its streak budget.
  always_comb begin
    pick = OWN_IF;
    if (if_req && ls_req) begin
      pick = (streak_reg == STREAK_MAX) ? OWN_IF : OWN_LS;
    end else if (ls_req) begin
      pick = OWN_LS;
    end
  end

  // Only LSU grants that happen while the IFU is actually waiting count
  // toward the streak; an idle IFU forgets any accumulated streak.
  always_comb begin
    streak_next = streak_reg;
    if (if_grant) begin
      streak_next = '0;
    end else if (ls_grant && if_req) begin
      if (streak_reg != STREAK_MAX) begin
        streak_next = streak_reg + SW'(1);
      end
    end else if (idle && !if_req) begin
      streak_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// ysyx_22050612_mem_arbiter
//   Two-master (IFU read port, LSU read/write port) to one memory port
//   arbiter with a single outstanding transaction.
//   IDLE -> REQ -> RESP -> IDLE; payload is latched in IDLE so masters may
//   change their inputs once granted.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr               IFU fetch request
//   if_gnt/if_rvalid/if_rdata    IFU accept pulse and read response
//   ls_req/ls_wen/ls_addr/
//   ls_wdata/ls_wmask            LSU request and payload
//   ls_gnt/ls_rvalid/ls_rdata    LSU accept pulse and response
//   mem_valid/mem_ready          downstream request handshake
//   mem_wen/addr/wdata/wmask     downstream payload
//   mem_rvalid/mem_rdata         downstream response
module ysyx_22050612_mem_arbiter
  import ysyx_22050612_pkg::*;
#(
  parameter int MAX_LS_STREAK = DEFAULT_MAX_LS_STREAK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [63:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_wen,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [63:0] ls_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  state_e   state_reg, state_next;
  owner_e   owner_reg, owner_next;
  mem_req_t pay_reg, pay_next;
  owner_e   pick;

  ysyx_22050612_arb_pick #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .ls_req   (ls_req),
    .idle     (state_reg == ST_IDLE),
    .if_grant (if_gnt),
    .ls_grant (ls_gnt),
    .pick     (pick)
  );

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    pay_next   = pay_reg;
    mem_valid  = 1'b0;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    ls_rvalid  = 1'b0;
    if_rdata   = '0;
    ls_rdata   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (if_req || ls_req) begin
          owner_next = pick;
          if (pick == OWN_LS) begin
            pay_next = '{wen: ls_wen, addr: ls_addr, wdata: ls_wdata, wmask: ls_wmask};
          end else begin
            pay_next = '{wen: 1'b0, addr: if_addr, wdata: 64'd0, wmask: 8'd0};
          end
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          if (owner_reg == OWN_LS) ls_gnt = 1'b1;
          else                     if_gnt = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // Response is forwarded in the same cycle it arrives.
        if (mem_rvalid) begin
          if (owner_reg == OWN_LS) begin
            ls_rvalid = 1'b1;
            ls_rdata  = mem_rdata;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWN_IF;
      pay_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      pay_reg   <= pay_next;
    end
  end

  assign mem_wen   = pay_reg.wen;
  assign mem_addr  = pay_reg.addr;
  assign mem_wdata = pay_reg.wdata;
  assign mem_wmask = pay_reg.wmask;

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
module tb_ysyx_22050612_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        ls_req, ls_wen;
  logic [63:0] ls_addr, ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_gnt, ls_rvalid;
  logic [63:0] ls_rdata;
  logic        mem_valid, mem_ready, mem_wen;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  ysyx_22050612_mem_arbiter #(.MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: is a transaction open, has it been
  // accepted downstream, who owns it, what payload it carries.
  bit          m_busy, m_acc, m_own_ls, m_wen;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  int          m_streak;
  bit          e_if_gnt, e_ls_gnt;
  byte         gq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven; compare outputs against the
  // reference, advance the reference, then move to the next negedge.
  task automatic cycle();
    bit          e_mv, e_ig, e_lg, e_iv, e_lv;
    logic [63:0] e_if_rd, e_ls_rd;
    #1;
    if (rst) begin
      m_busy = 0; m_acc = 0; m_own_ls = 0; m_wen = 0;
      m_addr = '0; m_wdata = '0; m_wmask = '0; m_streak = 0;
      e_if_gnt = 0; e_ls_gnt = 0;
    end else begin
      e_mv = m_busy && !m_acc;
      e_ig = e_mv && mem_ready && !m_own_ls;
      e_lg = e_mv && mem_ready && m_own_ls;
      e_iv = m_busy && m_acc && mem_rvalid && !m_own_ls;
      e_lv = m_busy && m_acc && mem_rvalid && m_own_ls;
      e_if_rd = e_iv ? mem_rdata : 64'd0;
      e_ls_rd = e_lv ? mem_rdata : 64'd0;
      chk("strobes", 64'({mem_valid, if_gnt, ls_gnt, if_rvalid, ls_rvalid}),
          64'({e_mv, e_ig, e_lg, e_iv, e_lv}));
      chk("if_rdata", if_rdata, e_if_rd);
      chk("ls_rdata", ls_rdata, e_ls_rd);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wen_wmask", 64'({mem_wen, mem_wmask}), 64'({m_wen, m_wmask}));
      if (if_gnt) gq.push_back(8'h49);
      if (ls_gnt) gq.push_back(8'h4C);
      if (!m_busy) begin
        if (!if_req) m_streak = 0;
        if (if_req || ls_req) begin
          m_own_ls = ls_req && !(if_req && m_streak == MAXS);
          if (m_own_ls) begin
            m_wen = ls_wen; m_addr = ls_addr; m_wdata = ls_wdata; m_wmask = ls_wmask;
          end else begin
            m_wen = 0; m_addr = if_addr; m_wdata = '0; m_wmask = '0;
          end
          m_busy = 1; m_acc = 0;
        end
      end else if (!m_acc) begin
        if (mem_ready) begin
          m_acc = 1;
          if (m_own_ls) begin
            if (if_req && m_streak < MAXS) m_streak++;
          end else begin
            m_streak = 0;
          end
        end
      end else if (mem_rvalid) begin
        m_busy = 0;
      end
      e_if_gnt = e_ig;
      e_ls_gnt = e_lg;
    end
    @(negedge clk);
  endtask

  initial begin
    string order_s;
    int    n;
    rst = 1; if_req = 0; if_addr = '0; ls_req = 0; ls_wen = 0; ls_addr = '0;
    ls_wdata = '0; ls_wmask = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    @(negedge clk);
    cycle(); cycle();
    rst = 0;
    // Reset state: everything quiet and zero.
    cycle();

    // IFU fetch, immediate accept, response two cycles after grant.
    if_req = 1; if_addr = 64'h8000_0000; mem_ready = 1;
    cycle();
    cycle();
    if_req = 0; if_addr = 64'h1234;
    cycle();
    mem_rvalid = 1; mem_rdata = 64'h13;
    #1; chk("ifu_rdata_const", if_rdata, 64'h13);
    chk("ifu_ls_quiet", 64'({ls_gnt, ls_rvalid, ls_rdata}), 64'd0);
    cycle();
    mem_rvalid = 0;

    // LSU write: payload must appear unchanged downstream.
    ls_req = 1; ls_wen = 1; ls_addr = 64'h8000_1004;
    ls_wdata = 64'hDEAD_BEEF_0000_0000; ls_wmask = 8'hF0;
    cycle();
    #1; chk("lsu_wr_payload", 64'({mem_valid, mem_wen, mem_wmask}), 64'({1'b1, 1'b1, 8'hF0}));
    chk("lsu_wr_addr", mem_addr, 64'h8000_1004);
    chk("lsu_wr_data", mem_wdata, 64'hDEAD_BEEF_0000_0000);
    cycle();
    ls_req = 0; ls_wen = 0;
    mem_rvalid = 1; mem_rdata = '0;
    #1; chk("lsu_wr_ack", 64'(ls_rvalid), 64'd1);
    cycle();
    mem_rvalid = 0;

    // Downstream stalls five cycles; request held stable throughout.
    ls_req = 1; ls_addr = 64'h8000_2008; mem_ready = 0;
    cycle();
    repeat (5) cycle();
    mem_ready = 1;
    cycle();
    ls_req = 0; ls_addr = {$urandom, $urandom};
    mem_rvalid = 1; mem_rdata = {$urandom, $urandom};
    cycle();
    mem_rvalid = 0;

    // Continuous contention: streak limit forces periodic IFU grants.
    rst = 1; cycle(); rst = 0;
    gq.delete();
    if_req = 1; if_addr = 64'h8000_0100; ls_req = 1; ls_addr = 64'h8000_3000;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 64'h55;
    n = 0;
    while (gq.size() < 10 && n < 100) begin cycle(); n++; end
    order_s = "LLLLILLLLI";
    chk("grant_order_count", 64'(gq.size() >= 10), 64'd1);
    for (int k = 0; k < 10 && k < gq.size(); k++)
      chk($sformatf("grant_order_%0d", k), 64'(gq[k]), 64'(order_s[k]));
    if_req = 0; ls_req = 0;
    repeat (3) cycle();
    mem_rvalid = 0;

    // Reset while waiting for a response; stale response afterwards.
    ls_req = 1; ls_addr = 64'h8000_4000;
    cycle();
    cycle();
    ls_req = 0;
    cycle();
    rst = 1; cycle(); rst = 0;
    mem_rvalid = 1; mem_rdata = 64'hBAD0_BAD0;
    #1; chk("stale_rvalid", 64'({if_rvalid, ls_rvalid, mem_valid, mem_addr}), 64'd0);
    cycle();
    // Spurious responses while idle with nobody requesting.
    repeat (3) cycle();
    mem_rvalid = 0;

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (e_if_gnt) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = {$urandom, $urandom};
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = {$urandom, $urandom};
      end
      if (e_ls_gnt || (!ls_req && $urandom_range(0, 3) == 0)) begin
        ls_req = e_ls_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        ls_wen = 1'($urandom_range(0, 1)); ls_addr = {$urandom, $urandom};
        ls_wdata = {$urandom, $urandom}; ls_wmask = 8'($urandom);
      end
      mem_ready  = ($urandom_range(0, 3) != 0);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = {$urandom, $urandom};
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
